npu_conv_sequencer: RTL and testbench

NPU_CONV_SEQUENCER -- requirements
Module: npu_conv_sequencer

---
 rtl/npu_pkg.sv | 9 +
 rtl/npu_conv_sequencer_if.sv | 27 ++
 rtl/npu_tap_counter.sv | 20 ++
 rtl/npu_conv_sequencer.sv | 86 ++++++++
 tb/tb_npu_conv_sequencer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/npu_pkg.sv
// npu_pkg: shared defaults, select widths and sequencer state encoding
package npu_pkg;
  localparam int N_DEF = 10;
  localparam int K_SIZE_DEF = 3;
  localparam int TAPS_DEF = K_SIZE_DEF * K_SIZE_DEF;
  localparam int SEL_A_W = $clog2(TAPS_DEF);
  localparam int SEL_B_W = $clog2(2 * TAPS_DEF);
  typedef enum logic [2:0] {IDLE, CLEAR, MAC, DRAIN, DONE} state_e;
endpackage

// File: rtl/npu_conv_sequencer_if.sv
// npu_conv_sequencer_if: run control, config and PE control bundle of the conv sequencer
interface npu_conv_sequencer_if
  import npu_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = SEL_A_W,
  parameter int BW = SEL_B_W
);
  logic          start, abort;
  logic [N-1:0]  cfg_pe_mask;
  logic          cfg_bcast, cfg_mode_sel, cfg_acc_keep, buf_wr_req;
  logic [N-1:0]  pe_en, pe_mode_sel, pe_reg_reset;
  logic [AW-1:0] pe_mux_a_sel;
  logic [BW-1:0] pe_mux_b_sel;
  logic          busy, done, aborted, wr_conflict;
  logic [15:0]   run_cnt;
  modport master (
    output start, abort, cfg_pe_mask, cfg_bcast, cfg_mode_sel, cfg_acc_keep, buf_wr_req,
    input  pe_en, pe_mode_sel, pe_reg_reset, pe_mux_a_sel, pe_mux_b_sel,
           busy, done, aborted, wr_conflict, run_cnt
  );
  modport slave (
    input  start, abort, cfg_pe_mask, cfg_bcast, cfg_mode_sel, cfg_acc_keep, buf_wr_req,
    output pe_en, pe_mode_sel, pe_reg_reset, pe_mux_a_sel, pe_mux_b_sel,
           busy, done, aborted, wr_conflict, run_cnt
  );
endinterface

// File: rtl/npu_tap_counter.sv
// npu_tap_counter: kernel tap index 0..TAPS-1 with last-tap flag
module npu_tap_counter #(
  parameter int TAPS = 9,
  parameter int W    = $clog2(TAPS)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (load_i) cnt_q <= '0;
    else if (en_i) cnt_q <= last_o ? '0 : cnt_q + W'(1);
  assign cnt_o  = cnt_q;
  assign last_o = cnt_q == W'(TAPS - 1);
endmodule

// File: rtl/npu_conv_sequencer.sv
// npu_conv_sequencer: sequences clear / MAC taps / drain / done for a PE array.
// Outputs are registered from the next state so they line up with the state they describe.
module npu_conv_sequencer
  import npu_pkg::*;
#(
  parameter int N               = N_DEF,
  parameter int K_SIZE          = K_SIZE_DEF,
  parameter int PE_LAT          = 1,
  parameter int SEL_MUX_A_WIDTH = $clog2(K_SIZE * K_SIZE),
  parameter int SEL_MUX_B_WIDTH = $clog2(2 * K_SIZE * K_SIZE)
) (
  input logic clk,
  input logic rst_n,
  npu_conv_sequencer_if.slave bus
);
  localparam int TAPS = K_SIZE * K_SIZE;
  localparam int AW = SEL_MUX_A_WIDTH;
  localparam int BW = SEL_MUX_B_WIDTH;
  state_e state_q, state_d;
  logic [N-1:0] mask_q, m, en_q, en_d, rst_q, rst_d, mode_q, mode_d;
  logic bcast_q, bc, msel_q, md, keep_q, kp, accept, last;
  logic [AW-1:0] tap, tap_nxt, a_q, a_d;
  logic [BW-1:0] b_q, b_d;
  logic [2:0] drain_q;
  logic done_q, done_d, busy_q, busy_d, abt_q, abt_d, wrc_q, wrc_d;
  logic [15:0] cnt_q, run_cnt_q;
  npu_tap_counter #(.TAPS(TAPS), .W(AW)) u_tap (
    .clk(clk), .rst_n(rst_n),
    .load_i(state_d == MAC && state_q != MAC),
    .en_i(state_q == MAC && state_d == MAC),
    .cnt_o(tap), .last_o(last)
  );
  always_comb begin
    accept = state_q == IDLE && bus.start && !bus.abort;
    m  = accept ? bus.cfg_pe_mask : mask_q;
    bc = accept ? bus.cfg_bcast : bcast_q;
    md = accept ? bus.cfg_mode_sel : msel_q;
    kp = accept ? bus.cfg_acc_keep : keep_q;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !accept ? IDLE : m == '0 ? DONE : kp ? MAC : CLEAR;
      CLEAR:   state_d = MAC;
      MAC:     state_d = !last ? MAC : PE_LAT == 0 ? DONE : DRAIN;
      DRAIN:   state_d = drain_q == 3'(PE_LAT - 1) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
    if (bus.abort && state_q != IDLE) state_d = IDLE;
    tap_nxt = state_q == MAC ? tap + AW'(1) : '0;
    en_d    = state_d == MAC ? m : '0;
    rst_d   = state_d == CLEAR ? m : '0;
    mode_d  = md && (state_d inside {CLEAR, MAC, DRAIN}) ? m : '0;
    a_d     = state_d == MAC ? tap_nxt : '0;
    b_d     = state_d == MAC ? BW'(tap_nxt) + (bc ? BW'(TAPS) : '0) : '0;
    busy_d  = state_d != IDLE;
    done_d  = state_d == DONE;
    abt_d   = bus.abort && state_q != IDLE;
    wrc_d   = accept ? 1'b0 : wrc_q | (bus.buf_wr_req && state_q != IDLE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      {mask_q, bcast_q, msel_q, keep_q} <= '0;
      {en_q, rst_q, mode_q, a_q, b_q} <= '0;
      {busy_q, done_q, abt_q, wrc_q} <= '0;
      drain_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      {mask_q, bcast_q, msel_q, keep_q} <= {m, bc, md, kp};
      {en_q, rst_q, mode_q, a_q, b_q} <= {en_d, rst_d, mode_d, a_d, b_d};
      {busy_q, done_q, abt_q, wrc_q} <= {busy_d, done_d, abt_d, wrc_d};
      drain_q <= state_q == DRAIN ? drain_q + 3'd1 : '0;
      if (done_d) cnt_q <= cnt_q + 16'd1;
    end
  assign run_cnt_q        = cnt_q;
  assign bus.pe_en        = en_q;
  assign bus.pe_reg_reset = rst_q;
  assign bus.pe_mode_sel  = mode_q;
  assign bus.pe_mux_a_sel = a_q;
  assign bus.pe_mux_b_sel = b_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.aborted      = abt_q;
  assign bus.wr_conflict  = wrc_q;
  assign bus.run_cnt      = run_cnt_q;
endmodule

// File: tb/tb_npu_conv_sequencer.sv
// tb_npu_conv_sequencer: scoreboard bench; per-cycle PE control expectations come from a spec model
module tb_npu_conv_sequencer;
  import npu_pkg::*;
  typedef struct packed {
    logic [9:0] en, rst, mode;
    logic [3:0] a;
    logic [4:0] b;
    logic busy, done;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  npu_conv_sequencer_if bus ();
  npu_conv_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  exp_t sb[$];
  exp_t mon_e, mon_a;
  int passed = 0, total = 0;
  logic [15:0] exp_cnt = '0;

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      mon_a.en = bus.pe_en; mon_a.rst = bus.pe_reg_reset; mon_a.mode = bus.pe_mode_sel;
      mon_a.a = bus.pe_mux_a_sel; mon_a.b = bus.pe_mux_b_sel;
      mon_a.busy = bus.busy; mon_a.done = bus.done;
      total++;
      if (mon_a !== mon_e)
        $display("FAIL seq @%0t got en=%h rst=%h mode=%h a=%0d b=%0d busy=%b done=%b want en=%h rst=%h mode=%h a=%0d b=%0d busy=%b done=%b",
          $time, mon_a.en, mon_a.rst, mon_a.mode, mon_a.a, mon_a.b, mon_a.busy, mon_a.done,
          mon_e.en, mon_e.rst, mon_e.mode, mon_e.a, mon_e.b, mon_e.busy, mon_e.done);
      else passed++;
    end
  end

  task automatic launch(input logic [9:0] m, input logic bc, input logic md, input logic kp, input int limit);
    exp_t tmp[$];
    exp_t e;
    logic [9:0] mm;
    mm = md ? m : '0;
    if (m != '0 && !kp) begin e = '0; e.rst = m; e.mode = mm; e.busy = 1'b1; tmp.push_back(e); end
    if (m != '0) begin
      for (int t = 0; t < 9; t++) begin
        e = '0; e.en = m; e.mode = mm; e.a = 4'(t); e.b = 5'(t + (bc ? 9 : 0)); e.busy = 1'b1;
        tmp.push_back(e);
      end
      e = '0; e.mode = mm; e.busy = 1'b1; tmp.push_back(e);
    end
    e = '0; e.busy = 1'b1; e.done = 1'b1; tmp.push_back(e);
    e = '0; tmp.push_back(e);
    @(negedge clk);
    bus.cfg_pe_mask = m; bus.cfg_bcast = bc; bus.cfg_mode_sel = md; bus.cfg_acc_keep = kp;
    bus.start = 1'b1;
    for (int i = 0; i < tmp.size() && i < limit; i++) sb.push_back(tmp[i]);
    if (limit < tmp.size()) begin e = '0; sb.push_back(e); end
    else exp_cnt = exp_cnt + 16'd1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_sb(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      total++;
      $display("FAIL %s timeout pending=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b want=0", bus.busy); else passed++;
    total++; if (bus.pe_en !== '0) $display("FAIL rst_pe_en got=%h want=0", bus.pe_en); else passed++;
    total++; if (bus.run_cnt !== 16'h0) $display("FAIL rst_run_cnt got=%h want=0", bus.run_cnt); else passed++;
    total++; if ({bus.done, bus.aborted, bus.wr_conflict} !== 3'b0)
      $display("FAIL rst_flags got=%b want=000", {bus.done, bus.aborted, bus.wr_conflict}); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) $display("FAIL idle_busy got=%b want=0", bus.busy); else passed++;
  endtask

  task automatic test_full_run();
    launch(10'h3FF, 1'b0, 1'b0, 1'b0, 99);
    wait_sb("full_run");
    total++; if (bus.run_cnt !== exp_cnt) $display("FAIL full_run_cnt got=%h want=%h", bus.run_cnt, exp_cnt); else passed++;
  endtask

  task automatic test_bcast_keep();
    launch(10'h005, 1'b1, 1'b0, 1'b1, 99);
    wait_sb("bcast_keep");
    total++; if (bus.run_cnt !== exp_cnt) $display("FAIL bcast_cnt got=%h want=%h", bus.run_cnt, exp_cnt); else passed++;
  endtask

  task automatic test_mask_zero();
    launch(10'h000, 1'b0, 1'b1, 1'b0, 99);
    wait_sb("mask_zero");
    total++; if (bus.run_cnt !== exp_cnt) $display("FAIL mask0_cnt got=%h want=%h", bus.run_cnt, exp_cnt); else passed++;
  endtask

  task automatic test_abort();
    launch(10'h3FF, 1'b0, 1'b1, 1'b0, 6);
    repeat (5) @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.aborted !== 1'b1) $display("FAIL abort_pulse got=%b want=1", bus.aborted); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL abort_done got=%b want=0", bus.done); else passed++;
    total++; if (bus.run_cnt !== exp_cnt) $display("FAIL abort_cnt got=%h want=%h", bus.run_cnt, exp_cnt); else passed++;
    @(negedge clk);
    bus.abort = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.aborted !== 1'b0) $display("FAIL abort_one_cycle got=%b want=0", bus.aborted); else passed++;
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1; bus.cfg_pe_mask = 10'h3FF;
    @(posedge clk); #1;
    total++; if ({bus.busy, bus.aborted} !== 2'b00) $display("FAIL abort_start_idle got=%b want=00", {bus.busy, bus.aborted}); else passed++;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    wait_sb("abort");
  endtask

  task automatic test_ignore_busy();
    launch(10'h0F0, 1'b0, 1'b1, 1'b0, 99);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.cfg_pe_mask = 10'h3FF; bus.cfg_bcast = 1'b1;
    bus.cfg_mode_sel = 1'b0; bus.cfg_acc_keep = 1'b1; bus.buf_wr_req = 1'b1;
    @(negedge clk);
    bus.buf_wr_req = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    wait_sb("ignore_busy");
    total++; if (bus.wr_conflict !== 1'b1) $display("FAIL wr_conflict_set got=%b want=1", bus.wr_conflict); else passed++;
    repeat (3) @(negedge clk);
    total++; if (bus.busy !== 1'b0) $display("FAIL start_not_queued busy=%b want=0", bus.busy); else passed++;
    total++; if (bus.wr_conflict !== 1'b1) $display("FAIL wr_conflict_sticky got=%b want=1", bus.wr_conflict); else passed++;
  endtask

  task automatic test_back_to_back();
    launch(10'h201, 1'b0, 1'b0, 1'b1, 99);
    total++; if (bus.wr_conflict !== 1'b0) $display("FAIL wr_conflict_clear got=%b want=0", bus.wr_conflict); else passed++;
    wait_sb("b2b_first");
    launch(10'h3FF, 1'b1, 1'b1, 1'b0, 99);
    wait_sb("b2b_second");
    total++; if (bus.run_cnt !== exp_cnt) $display("FAIL b2b_cnt got=%h want=%h", bus.run_cnt, exp_cnt); else passed++;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.run_cnt_q = 16'hFFFF;
    #1 release dut.run_cnt_q;
    force dut.cnt_q = 16'hFFFF;
    #1 release dut.cnt_q;
    total++; if (bus.run_cnt !== 16'hFFFF) $display("FAIL preload got=%h want=ffff", bus.run_cnt); else passed++;
    exp_cnt = 16'hFFFF;
    launch(10'h000, 1'b0, 1'b0, 1'b0, 99);
    wait_sb("wrap");
    total++; if (bus.run_cnt !== 16'h0000) $display("FAIL wrap_cnt got=%h want=0000", bus.run_cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    launch(10'h3FF, 1'b0, 1'b1, 1'b0, 4);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if ({bus.pe_en, bus.pe_mode_sel, bus.pe_reg_reset} !== 30'h0)
      $display("FAIL rst_mid_pe got=%h want=0", {bus.pe_en, bus.pe_mode_sel, bus.pe_reg_reset}); else passed++;
    total++; if ({bus.pe_mux_a_sel, bus.pe_mux_b_sel} !== 9'h0)
      $display("FAIL rst_mid_sel got=%h want=0", {bus.pe_mux_a_sel, bus.pe_mux_b_sel}); else passed++;
    total++; if ({bus.busy, bus.done, bus.aborted, bus.wr_conflict} !== 4'b0)
      $display("FAIL rst_mid_flags got=%b want=0000", {bus.busy, bus.done, bus.aborted, bus.wr_conflict}); else passed++;
    total++; if (bus.run_cnt !== 16'h0) $display("FAIL rst_mid_cnt got=%h want=0", bus.run_cnt); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    wait_sb("reset_mid");
    @(negedge clk);
    total++; if ({bus.busy, bus.aborted} !== 2'b00) $display("FAIL rst_mid_after got=%b want=00", {bus.busy, bus.aborted}); else passed++;
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_pe_mask = '0; bus.cfg_bcast = 1'b0;
    bus.cfg_mode_sel = 1'b0; bus.cfg_acc_keep = 1'b0; bus.buf_wr_req = 1'b0;
    test_reset();
    test_full_run();
    test_bcast_keep();
    test_mask_zero();
    test_abort();
    test_ignore_busy();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
